// File: rtl/run_det_pkg.sv
// Shared definitions for the run-length detector: FSM state encoding, mode codes
// and the mode gating that turns the two hit flags into the detect flag.
package run_det_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN0 = 2'b01,
      RUN1 = 2'b10
   } state_t;

   localparam logic [1:0] MODE_BOTH = 2'b00;
   localparam logic [1:0] MODE_ZERO = 2'b01;
   localparam logic [1:0] MODE_ONE  = 2'b10;
   localparam logic [1:0] MODE_OFF  = 2'b11;

   function automatic logic modeGate(input logic [1:0] mode,
                                     input logic zeroHit,
                                     input logic oneHit);
      return (zeroHit && (mode == MODE_BOTH || mode == MODE_ZERO)) ||
             (oneHit  && (mode == MODE_BOTH || mode == MODE_ONE));
   endfunction

endpackage

// File: rtl/run_length_detector_if.sv
// Control and status bundle of the run-length detector; the front end drives
// the master side and the detector sits on the slave side.
interface run_length_detector_if #(
   parameter int CNT_W = 4,
   parameter int HIT_W = 8
);
   logic             en;
   logic             clr;
   logic             w;
   logic [1:0]       mode;
   logic             b;
   logic             zero_hit;
   logic             one_hit;
   logic [CNT_W-1:0] run_len;
   logic             b_rise;
   logic [HIT_W-1:0] hit_cnt;

   modport master (
      output en, clr, w, mode,
      input  b, zero_hit, one_hit, run_len, b_rise, hit_cnt
   );

   modport slave (
      input  en, clr, w, mode,
      output b, zero_hit, one_hit, run_len, b_rise, hit_cnt
   );
endinterface

// File: rtl/run_length_detector_sat_counter.sv
// Saturating up-counter with synchronous clear and a load-to-one, used for both
// the current run length and the detect event count.
module sat_counter #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clr,
   input  logic         load1,
   input  logic         inc,
   output logic [W-1:0] q
);

   logic [W-1:0] r_q;

   // load1 outranks inc so a new run always restarts at one
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_q <= '0;
      end else if (clr) begin
         r_q <= '0;
      end else if (load1) begin
         r_q <= W'(1);
      end else if (inc && (r_q != {W{1'b1}})) begin
         r_q <= r_q + 1'b1;
      end
   end

   assign q = r_q;

endmodule

// File: rtl/run_length_detector.sv
// Tracks the run of identical bits on w, flags long runs of 0s or 1s, gates the
// flags by mode and counts rising edges of the gated detect flag.
module run_length_detector
   import run_det_pkg::*;
#(
   parameter int ZERO_RUN = 2,
   parameter int ONE_RUN  = 1,
   parameter int CNT_W    = 4,
   parameter int HIT_W    = 8
) (
   input logic                 clk,
   input logic                 rst_n,
   run_length_detector_if.slave bus
);

   localparam int RUN_MAX = (1 << CNT_W) - 1;

   generate
      if (ZERO_RUN < 1 || ZERO_RUN > RUN_MAX) begin : g_badZeroRun
         $error("run_length_detector: ZERO_RUN must lie in 1..2^CNT_W-1");
      end
      if (ONE_RUN < 1 || ONE_RUN > RUN_MAX) begin : g_badOneRun
         $error("run_length_detector: ONE_RUN must lie in 1..2^CNT_W-1");
      end
   endgenerate

   state_t             r_state;
   state_t             w_nextState;
   logic               w_runStart;
   logic               w_runCont;
   logic               w_runClear;
   logic [CNT_W-1:0]   w_runLen;
   logic [HIT_W-1:0]   w_hitCnt;
   logic               w_zeroHit;
   logic               w_oneHit;
   logic               w_b;
   logic               w_bRise;
   logic               r_bQ;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Next state plus the run counter controls: a change of bit starts a run,
   // a repeat continues it, and the unused encoding discards it.
   always_comb begin
      w_nextState = r_state;
      w_runStart  = 1'b0;
      w_runCont   = 1'b0;
      w_runClear  = bus.clr;
      if (bus.clr) begin
         w_nextState = IDLE;
      end else if (bus.en) begin
         case (r_state)
            IDLE: begin
               w_nextState = bus.w ? RUN1 : RUN0;
               w_runStart  = 1'b1;
            end
            RUN0: begin
               if (bus.w) begin
                  w_nextState = RUN1;
                  w_runStart  = 1'b1;
               end else begin
                  w_runCont = 1'b1;
               end
            end
            RUN1: begin
               if (!bus.w) begin
                  w_nextState = RUN0;
                  w_runStart  = 1'b1;
               end else begin
                  w_runCont = 1'b1;
               end
            end
            default: begin
               w_nextState = IDLE;
               w_runClear  = 1'b1;
            end
         endcase
      end
   end

   always_comb begin
      w_zeroHit = (r_state == RUN0) && (w_runLen >= CNT_W'(ZERO_RUN));
      w_oneHit  = (r_state == RUN1) && (w_runLen >= CNT_W'(ONE_RUN));
      w_b       = modeGate(bus.mode, w_zeroHit, w_oneHit);
      w_bRise   = w_b & ~r_bQ;
   end

   // Tracks b even while en is low so mode changes alone still yield edges
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_bQ <= 1'b0;
      end else if (bus.clr) begin
         r_bQ <= 1'b0;
      end else begin
         r_bQ <= w_b;
      end
   end

   sat_counter #(.W(CNT_W)) u_runLen (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (w_runClear),
      .load1 (w_runStart),
      .inc   (w_runCont),
      .q     (w_runLen)
   );

   sat_counter #(.W(HIT_W)) u_hitCnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (bus.clr),
      .load1 (1'b0),
      .inc   (w_bRise),
      .q     (w_hitCnt)
   );

   assign bus.b        = w_b;
   assign bus.zero_hit = w_zeroHit;
   assign bus.one_hit  = w_oneHit;
   assign bus.run_len  = w_runLen;
   assign bus.b_rise   = w_bRise;
   assign bus.hit_cnt  = w_hitCnt;

endmodule

// File: tb/tb_run_length_detector.sv
// Bench for run_length_detector: a default instance (A) and a narrow instance (B,
// ZERO_RUN=ONE_RUN=3, CNT_W=2, HIT_W=2) share stimulus and a run-based reference model.
module tb_run_length_detector;
   import run_det_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       en = 1'b0;
   logic       clr = 1'b0;
   logic       w = 1'b0;
   logic [1:0] mode = MODE_BOTH;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   run_length_detector_if #(.CNT_W(4), .HIT_W(8)) busA ();
   run_length_detector_if #(.CNT_W(2), .HIT_W(2)) busB ();

   assign busA.en   = en;
   assign busA.clr  = clr;
   assign busA.w    = w;
   assign busA.mode = mode;
   assign busB.en   = en;
   assign busB.clr  = clr;
   assign busB.w    = w;
   assign busB.mode = mode;

   run_length_detector #(.ZERO_RUN(2), .ONE_RUN(1), .CNT_W(4), .HIT_W(8)) dutA (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (busA.slave)
   );

   run_length_detector #(.ZERO_RUN(3), .ONE_RUN(3), .CNT_W(2), .HIT_W(2)) dutB (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (busB.slave)
   );

   // Reference model: the run is "last bit seen and how many times in a row"
   int zeroRun[2] = '{2, 3};
   int oneRun[2]  = '{1, 3};
   int runMax[2]  = '{15, 3};
   int hitMax[2]  = '{255, 3};
   bit mValid[2];
   bit mBit[2];
   int mRun[2];
   bit mBq[2];
   int mHit[2];

   function automatic int modelRunLen(int i);
      return (mRun[i] > runMax[i]) ? runMax[i] : mRun[i];
   endfunction

   function automatic bit modelZeroHit(int i);
      return mValid[i] && !mBit[i] && (modelRunLen(i) >= zeroRun[i]);
   endfunction

   function automatic bit modelOneHit(int i);
      return mValid[i] && mBit[i] && (modelRunLen(i) >= oneRun[i]);
   endfunction

   function automatic bit modelB(int i);
      return (modelZeroHit(i) && !mode[1]) || (modelOneHit(i) && !mode[0]);
   endfunction

   task automatic modelStep();
      for (int i = 0; i < 2; i++) begin
         bit bNow;
         bit rise;
         bNow = modelB(i);
         rise = bNow && !mBq[i];
         if (!rst_n || clr) begin
            mValid[i] = 1'b0;
            mBit[i]   = 1'b0;
            mRun[i]   = 0;
            mBq[i]    = 1'b0;
            mHit[i]   = 0;
         end else begin
            if (en) begin
               if (mValid[i] && (mBit[i] == w)) mRun[i] = mRun[i] + 1;
               else                             mRun[i] = 1;
               mValid[i] = 1'b1;
               mBit[i]   = w;
            end
            mBq[i] = bNow;
            if (rise && (mHit[i] < hitMax[i])) mHit[i] = mHit[i] + 1;
         end
      end
   endtask

   task automatic checkVal(input string name, input logic [31:0] act, input int expv);
      checks++;
      if (act !== 32'(expv)) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, expv, $time);
      end
   endtask

   task automatic checkOutput();
      checkVal("A.b",        32'(busA.b),        int'(modelB(0)));
      checkVal("A.zero_hit", 32'(busA.zero_hit), int'(modelZeroHit(0)));
      checkVal("A.one_hit",  32'(busA.one_hit),  int'(modelOneHit(0)));
      checkVal("A.run_len",  32'(busA.run_len),  modelRunLen(0));
      checkVal("A.b_rise",   32'(busA.b_rise),   int'(modelB(0) && !mBq[0]));
      checkVal("A.hit_cnt",  32'(busA.hit_cnt),  mHit[0]);
      checkVal("B.b",        32'(busB.b),        int'(modelB(1)));
      checkVal("B.zero_hit", 32'(busB.zero_hit), int'(modelZeroHit(1)));
      checkVal("B.one_hit",  32'(busB.one_hit),  int'(modelOneHit(1)));
      checkVal("B.run_len",  32'(busB.run_len),  modelRunLen(1));
      checkVal("B.b_rise",   32'(busB.b_rise),   int'(modelB(1) && !mBq[1]));
      checkVal("B.hit_cnt",  32'(busB.hit_cnt),  mHit[1]);
   endtask

   // Drive one cycle of inputs, clock them in, then settle at the falling edge
   task automatic applyStimulus(input logic r, input logic c, input logic e,
                                input logic wv, input logic [1:0] m);
      rst_n = r;
      clr   = c;
      en    = e;
      w     = wv;
      mode  = m;
      @(posedge clk);
      modelStep();
      @(negedge clk);
   endtask

   typedef struct {
      logic       rstN;
      logic       clrV;
      logic       enV;
      logic       wV;
      logic [1:0] modeV;
      logic       expB;
      int         expRun;
      int         expHit;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(logic r, logic c, logic e, logic wv, logic [1:0] m,
                               logic eb, int er, int eh);
      vec_t v;
      v.rstN = r; v.clrV = c; v.enV = e; v.wV = wv; v.modeV = m;
      v.expB = eb; v.expRun = er; v.expHit = eh;
      return v;
   endfunction

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int zhExp[5] = '{0, 0, 1, 1, 1};
      int rzExp[5] = '{1, 2, 3, 3, 3};
      int ohExp[4] = '{0, 0, 1, 1};
      int roExp[4] = '{1, 2, 3, 3};
      int hsExp[5] = '{1, 2, 3, 3, 3};

      // Reset with w toggling, then a quiet hold with en low
      tbl.push_back(mk(0, 0, 0, 0, MODE_BOTH, 0, 0, 0));
      tbl.push_back(mk(0, 0, 0, 1, MODE_BOTH, 0, 0, 0));
      for (int i = 0; i < 5; i++)
         tbl.push_back(mk(1, 0, 0, logic'(i % 2), MODE_BOTH, 0, 0, 0));
      // Legacy pattern 0,0,0,1,0,1,1
      tbl.push_back(mk(1, 0, 1, 0, MODE_BOTH, 0, 1, 0));
      tbl.push_back(mk(1, 0, 1, 0, MODE_BOTH, 1, 2, 0));
      tbl.push_back(mk(1, 0, 1, 0, MODE_BOTH, 1, 3, 1));
      tbl.push_back(mk(1, 0, 1, 1, MODE_BOTH, 1, 1, 1));
      tbl.push_back(mk(1, 0, 1, 0, MODE_BOTH, 0, 1, 1));
      tbl.push_back(mk(1, 0, 1, 1, MODE_BOTH, 1, 1, 1));
      tbl.push_back(mk(1, 0, 1, 1, MODE_BOTH, 1, 2, 2));
      // Mode sweep while holding the 1-run
      tbl.push_back(mk(1, 0, 0, 1, MODE_BOTH, 1, 2, 2));
      tbl.push_back(mk(1, 0, 0, 1, MODE_ZERO, 0, 2, 2));
      tbl.push_back(mk(1, 0, 0, 1, MODE_ONE,  1, 2, 3));
      tbl.push_back(mk(1, 0, 0, 1, MODE_OFF,  0, 2, 3));
      // Build a 0-run of two, then clear during a b_rise cycle
      tbl.push_back(mk(1, 0, 1, 0, MODE_BOTH, 0, 1, 4));
      tbl.push_back(mk(1, 0, 1, 0, MODE_BOTH, 1, 2, 4));
      tbl.push_back(mk(1, 1, 1, 0, MODE_BOTH, 0, 0, 0));
      tbl.push_back(mk(1, 0, 0, 1, MODE_BOTH, 0, 0, 0));
      tbl.push_back(mk(1, 0, 0, 0, MODE_BOTH, 0, 0, 0));

      @(negedge clk);
      for (int k = 0; k < tbl.size(); k++) begin
         applyStimulus(tbl[k].rstN, tbl[k].clrV, tbl[k].enV, tbl[k].wV, tbl[k].modeV);
         checkVal($sformatf("vec%0d.b", k),       32'(busA.b),       int'(tbl[k].expB));
         checkVal($sformatf("vec%0d.run_len", k), 32'(busA.run_len), tbl[k].expRun);
         checkVal($sformatf("vec%0d.hit_cnt", k), 32'(busA.hit_cnt), tbl[k].expHit);
         checkOutput();
      end

      // Narrow instance: run length saturates at 3 and hits hold while saturated
      applyStimulus(1, 1, 0, 0, MODE_OFF);
      checkOutput();
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1, 0, 1, 0, MODE_OFF);
         checkVal($sformatf("B.zrun%0d.zero_hit", i), 32'(busB.zero_hit), zhExp[i]);
         checkVal($sformatf("B.zrun%0d.run_len", i),  32'(busB.run_len),  rzExp[i]);
         checkOutput();
      end
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1, 0, 1, 1, MODE_OFF);
         checkVal($sformatf("B.orun%0d.one_hit", i), 32'(busB.one_hit), ohExp[i]);
         checkVal($sformatf("B.orun%0d.run_len", i), 32'(busB.run_len), roExp[i]);
         checkOutput();
      end
      // Mode toggling alone produces b_rise events; the 2-bit counter saturates
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1, 0, 0, 1, MODE_BOTH);
         checkVal($sformatf("B.sat%0d.hit_cnt", i), 32'(busB.hit_cnt), hsExp[i]);
         checkOutput();
         applyStimulus(1, 0, 0, 1, MODE_OFF);
         checkOutput();
      end

      // Randomized traffic with sticky w to grow long runs
      for (int n = 0; n < 400; n++) begin
         logic       r;
         logic       c;
         logic       e;
         logic       wv;
         logic [1:0] m;
         r  = ($urandom_range(0, 99) != 0);
         c  = ($urandom_range(0, 49) == 0);
         e  = ($urandom_range(0, 9) < 7);
         wv = ($urandom_range(0, 9) < 3) ? ~w : w;
         m  = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(0, 3)) : mode;
         applyStimulus(r, c, e, wv, m);
         checkOutput();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
